pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter and fetch stage: successor to the fixed 8-bit/20-bit program counter. Drives a synchronous instruction memory and returns each instruction with its address and a valid flag. Supports stall hold, absolute jump, PC-relative branch, and call/return through a return-address stack (RAS). Sits between the program memory and the decode stage.

## Interface
- `ADDR_W`, default 8: PC and memory address width.
- `INS_W`, default 20: instruction width.
- `OFF_W`, default 8: signed branch offset width; must be ≤ ADDR_W.
- `RAS_DEPTH`, default 4: return-stack entries; power of two, ≥2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `stall` in 1: 1 freezes PC, fetch and outputs; `pc_op` is ignored.
- `pc_op` in 3: 000 SEQ, 001 JMP, 010 BRA, 011 CALL, 100 RET; 101–111 are treated as SEQ.
- `jmp_loc` in ADDR_W: absolute target for JMP/CALL.
- `br_off` in OFF_W: signed offset for BRA.
- `imem_addr` out ADDR_W: equals the PC register.
- `imem_en` out 1: `~stall` while reset is high; 0 during reset.
- `imem_rdata` in INS_W: memory data, valid one cycle after an enabled address.
- `ins` out INS_W: current instruction.
- `ins_pc` out ADDR_W: address of `ins`.
- `ins_valid` out 1: `ins` is a committed-path instruction.
- `ras_overflow` out 1: one-cycle pulse on a CALL when the RAS is full.
- `ras_underflow` out 1: one-cycle pulse on a RET when the RAS is empty.

## Operation
- Reset (`reset`=0, async) clears:
  - `pc`, `ins_pc`, hold register, RAS pointer and count, `ins_valid`, both pulses → 0.
  - `imem_en` = 0; `ins` = 0.
- Enabled cycle (`stall`=0): PC loads next_pc.
  - SEQ: pc+1.
  - JMP: `jmp_loc`.
  - BRA: `ins_pc` + sign-extend(`br_off`).
  - CALL: `jmp_loc`, and push `ins_pc`+1.
  - RET: pop the top entry; if the RAS is empty, use `ins_pc`+1 and pulse `ras_underflow`.
- All arithmetic is modulo 2^ADDR_W; PC wraps from all-ones to 0.
- Redirect ops are JMP, BRA, CALL and RET. On a redirect in an enabled cycle, the fetch issued that cycle (pc) is squashed.
- `ins_valid` next cycle is 1 iff the cycle was enabled and was not a redirect.
- `ins_pc` register: in an enabled cycle, `ins_pc` ← pc.
- `ins` source:
  - `imem_rdata` if the previous cycle was enabled;
  - otherwise the hold register, which captures `ins` every cycle.
  - `ins` is therefore stable for the whole stall.
- Stalled cycle: pc, `ins_pc`, `ins_valid`, `ins` and the RAS are unchanged; no pulses.
- RAS is circular.
  - CALL when full: overwrite the oldest entry; count stays RAS_DEPTH; pulse `ras_overflow`.
  - Count saturates at RAS_DEPTH and 0.
- `pc_op` is applied even when `ins_valid`=0. Decode must issue only SEQ for invalid `ins`.

## Timing
- Fetch latency is 1 cycle: address at edge t gives `ins` and `ins_valid` at t+1.
- First edge after `reset` rises:
  - `imem_addr` = 0 before it; pc=1 after it;
  - `ins` = mem[0], `ins_pc` = 0, `ins_valid` = 1.
- Redirect penalty is 1 bubble.
  - Op at cycle t gives `ins_valid`=0 at t+1.
  - Target instruction is valid at t+2.
- Back-to-back redirects: each enabled redirect squashes one fetch. No other interaction.
- Stall acts immediately in the cycle it is high. The release cycle behaves as a normal enabled cycle.
- Reset mid-operation: all outputs go to reset values asynchronously; no partial RAS update.

## Structure
- Package `pc_fetch_pkg`: `pc_op` enum (SEQ/JMP/BRA/CALL/RET) and width-check constants.
- Sub-module `pc_ras` (parameters ADDR_W, RAS_DEPTH):
  - Ports: push, pop, push_data, top, empty, full, overflow, underflow; same clock/reset.
  - The top level holds the PC mux, squash logic and the hold register.

## Test plan
- Reset release with memory holding mem[i]=i+0x100, `pc_op`=SEQ:
  - `ins_pc` 0,1,2,… with `ins` 0x100,0x101,…;
  - `ins_valid` continuously 1 from the first edge.
- Stall for 3 cycles while `ins_pc`=5: `ins`, `ins_pc`, `imem_addr`=6 and `ins_valid` frozen; on release, `ins_pc`=6 follows.
- BRA with `br_off`=-3 (0xFD) while `ins_pc`=0x02:
  - one cycle `ins_valid`=0;
  - then `ins_pc`=0xFF (wrap), `ins`=mem[0xFF].
- CALL to 0x40 at `ins_pc`=0x10, SEQ to 0x42, then RET: `ins_pc` sequence 0x40,0x41,0x42, bubble, 0x11.
- Five nested CALLs with RAS_DEPTH=4:
  - `ras_overflow` pulses on the 5th CALL;
  - four RETs return to the newest four addresses;
  - 5th RET pulses `ras_underflow` and falls through to `ins_pc`+1.
- `reset` pulled low mid-JMP at a non-clock instant:
  - outputs are 0 immediately, `imem_en`=0;
  - after release, fetch restarts from address 0 with an empty RAS.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// pc_fetch_pkg : shared opcode encoding and sizing helpers for the fetch stage
// Revision 1.0
// ============================================================================
package pc_fetch_pkg;

  localparam int OP_W          = 3;
  localparam int RAS_DEPTH_MIN = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRA  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // Pointer width for a power-of-two return stack; never narrower than one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth > RAS_DEPTH_MIN) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : circular return-address stack with overflow/underflow pulses
// Revision 1.0
// ============================================================================
module pc_ras
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W:0]    count;

  assign top_idx = ptr - PTR_W'(1);
  assign top     = stack[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);

  // ptr always points at the next write slot, which is also the oldest entry
  // once the stack is full, so a full push overwrites the oldest naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      overflow  <= push & full;
      underflow <= pop & empty;
      if (push) begin
        stack[ptr] <= push_data;
        ptr        <= ptr + PTR_W'(1);
        if (!full) begin
          count <= count + (PTR_W+1)'(1);
        end
      end else if (pop && !empty) begin
        ptr   <= top_idx;
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : program counter + one-cycle fetch stage with branch/call/RAS
// Revision 1.0
// ============================================================================
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int INS_W     = 20,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [OP_W-1:0]   pc_op,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic [OFF_W-1:0]  br_off,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] seq_ins_pc;
  logic [ADDR_W-1:0] ras_top;
  logic [INS_W-1:0]  hold;
  logic              prev_en;
  logic              redirect;
  logic              push;
  logic              pop;
  logic              ras_empty;
  logic              ras_full_unused;

  assign off_ext    = ADDR_W'($signed(br_off));
  assign seq_ins_pc = ins_pc + ADDR_W'(1);

  always_comb begin
    next_pc  = pc + ADDR_W'(1);
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (!stall) begin
      case (pc_op)
        OP_JMP: begin
          next_pc  = jmp_loc;
          redirect = 1'b1;
        end
        OP_BRA: begin
          next_pc  = ins_pc + off_ext;
          redirect = 1'b1;
        end
        OP_CALL: begin
          next_pc  = jmp_loc;
          push     = 1'b1;
          redirect = 1'b1;
        end
        OP_RET: begin
          next_pc  = ras_empty ? seq_ins_pc : ras_top;
          pop      = 1'b1;
          redirect = 1'b1;
        end
        default: ;
      endcase
    end
  end

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(seq_ins_pc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full_unused),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );

  // The hold register tracks ins every cycle so a stall can replay it while
  // the memory is disabled and its read data may be stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
      prev_en   <= 1'b0;
      hold      <= '0;
    end else begin
      hold    <= ins;
      prev_en <= ~stall;
      if (!stall) begin
        pc        <= next_pc;
        ins_pc    <= pc;
        ins_valid <= ~redirect;
      end
    end
  end

  assign ins       = prev_en ? imem_rdata : hold;
  assign imem_addr = pc;
  assign imem_en   = reset & ~stall;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : scoreboard bench with a queue-based reference model
// Revision 1.0
// ============================================================================
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int INS_W     = 20;
  localparam int OFF_W     = 8;
  localparam int RAS_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [OP_W-1:0]   pc_op = '0;
  logic [ADDR_W-1:0] jmp_loc = '0;
  logic [OFF_W-1:0]  br_off = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_en;
  logic [INS_W-1:0]  imem_rdata = '0;
  logic [INS_W-1:0]  ins;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_valid;
  logic              ras_overflow;
  logic              ras_underflow;

  logic [INS_W-1:0] mem [256];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              en;
    logic              ovf;
    logic              unf;
    logic [ADDR_W-1:0] ipc;
    logic [INS_W-1:0]  ins;
    bit                fresh;
  } cyc_t;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } txn_t;

  cyc_t cyc_q[$];
  txn_t ins_q[$];

  // Reference model state: architectural PC, presented instruction, and a
  // plain queue as the return stack (back = newest).
  logic [ADDR_W-1:0] m_pc = '0;
  logic [ADDR_W-1:0] m_ins_pc = '0;
  logic [INS_W-1:0]  m_ins = '0;
  logic              m_valid = 1'b0;
  logic [ADDR_W-1:0] m_ras[$];

  pc_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INS_W    (INS_W),
    .OFF_W    (OFF_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_op        (pc_op),
    .jmp_loc      (jmp_loc),
    .br_off       (br_off),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .ins_valid    (ins_valid),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  function automatic logic [INS_W-1:0] memval(input logic [ADDR_W-1:0] a);
    return INS_W'(a) + INS_W'(20'h100);
  endfunction

  initial for (int i = 0; i < 256; i++) mem[i] = memval(ADDR_W'(i));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_ins_pc = '0;
    m_ins = '0;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  // Drive one cycle of stimulus, advance the model across the coming edge,
  // queue what the DUT must show afterwards, then wait for the next cycle.
  task automatic step(input logic [2:0] op, input bit stl,
                      input logic [ADDR_W-1:0] jl, input logic [OFF_W-1:0] off);
    cyc_t e;
    txn_t t;
    logic [ADDR_W-1:0] nxt;
    bit redir;
    pc_op = op; stall = stl; jmp_loc = jl; br_off = off;
    e.en = !stl; e.ovf = 1'b0; e.unf = 1'b0; e.fresh = !stl;
    if (!stl) begin
      redir = 1'b1;
      nxt = ADDR_W'(m_pc + 1);
      case (op)
        3'd1: nxt = jl;
        3'd2: nxt = ADDR_W'(int'(m_ins_pc) + int'($signed(off)));
        3'd3: begin
          nxt = jl;
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1'b1;
          end
          m_ras.push_back(ADDR_W'(m_ins_pc + 1));
        end
        3'd4: begin
          if (m_ras.size() == 0) begin
            nxt = ADDR_W'(m_ins_pc + 1);
            e.unf = 1'b1;
          end else begin
            nxt = m_ras.pop_back();
          end
        end
        default: redir = 1'b0;
      endcase
      if (!redir) begin
        t.pc = m_pc;
        t.ins = memval(m_pc);
        ins_q.push_back(t);
      end
      m_valid = !redir;
      m_ins_pc = m_pc;
      m_ins = memval(m_pc);
      m_pc = nxt;
    end
    e.addr = m_pc; e.valid = m_valid; e.ipc = m_ins_pc; e.ins = m_ins;
    cyc_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'h0);
    check({tag, "_imem_en"}, 32'(imem_en), 32'h0);
    check({tag, "_ins"}, 32'(ins), 32'h0);
    check({tag, "_ins_pc"}, 32'(ins_pc), 32'h0);
    check({tag, "_ins_valid"}, 32'(ins_valid), 32'h0);
    check({tag, "_ovf"}, 32'(ras_overflow), 32'h0);
    check({tag, "_unf"}, 32'(ras_underflow), 32'h0);
  endtask

  // Monitor: per-cycle state plus an in-order scoreboard of fresh valid fetches.
  always @(negedge clk) begin
    cyc_t e;
    txn_t t;
    if (reset && cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("imem_addr", 32'(imem_addr), 32'(e.addr));
      check("imem_en", 32'(imem_en), 32'(e.en));
      check("ins_valid", 32'(ins_valid), 32'(e.valid));
      check("ins_pc", 32'(ins_pc), 32'(e.ipc));
      check("ins", 32'(ins), 32'(e.ins));
      check("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(e.unf));
      if (e.fresh && ins_valid) begin
        if (ins_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=valid ins_pc %h expected=no instruction", ins_pc);
        end else begin
          t = ins_q.pop_front();
          check("sb_ins_pc", 32'(ins_pc), 32'(t.pc));
          check("sb_ins", 32'(ins), 32'(t.ins));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("por");
    @(negedge clk); #1;
    reset = 1'b1;

    // Sequential fetch from 0, then a 3-cycle stall with an ignored CALL.
    repeat (6) step(3'd0, 1'b0, '0, '0);
    repeat (3) step(3'd3, 1'b1, 8'h99, '0);
    repeat (2) step(3'd0, 1'b0, '0, '0);

    // Negative branch wrapping below zero.
    step(3'd1, 1'b0, 8'h02, '0);
    step(3'd0, 1'b0, '0, '0);
    step(3'd2, 1'b0, '0, 8'hFD);
    repeat (3) step(3'd0, 1'b0, '0, '0);

    // Call / return pair.
    step(3'd1, 1'b0, 8'h10, '0);
    step(3'd0, 1'b0, '0, '0);
    step(3'd3, 1'b0, 8'h40, '0);
    repeat (3) step(3'd0, 1'b0, '0, '0);
    step(3'd4, 1'b0, '0, '0);
    repeat (2) step(3'd0, 1'b0, '0, '0);

    // Five nested calls overflow the four-entry stack; five returns underflow.
    for (int k = 0; k < 5; k++) begin
      step(3'd3, 1'b0, ADDR_W'(8'h20 + 16 * k), '0);
      step(3'd0, 1'b0, '0, '0);
    end
    for (int k = 0; k < 5; k++) begin
      step(3'd4, 1'b0, '0, '0);
      step(3'd0, 1'b0, '0, '0);
    end

    // Asynchronous reset mid-JMP, between clock edges.
    check("sb_empty_before_reset", 32'(ins_q.size()), 32'h0);
    pc_op = 3'd1; jmp_loc = 8'h77; stall = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clk); #1;
    model_reset();
    reset = 1'b1;
    repeat (4) step(3'd0, 1'b0, '0, '0);
    step(3'd4, 1'b0, '0, '0);
    step(3'd0, 1'b0, '0, '0);

    // Randomised operation mix including reserved opcodes and stalls.
    repeat (400) begin
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
           ADDR_W'($urandom), OFF_W'($urandom));
    end
    repeat (3) step(3'd0, 1'b0, '0, '0);

    check("sb_drained", 32'(ins_q.size()), 32'h0);
    check("cyc_drained", 32'(cyc_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
